c_usample: RTL and testbench
============================

# c_usample

Converts a 4:2:2 AXI4-Stream video stream (16-bit beats, chroma alternating per pixel) back into 4:4:4 (24-bit beats, full chroma on every pixel). It sits on the input path from the 4:2:2 frame buffer reader toward the HDMI output or the 4:4:4 processing cores, directly opposite `c_rsample`-style 4:4:4→4:2:2 downsampling. Each even/odd pixel pair is buffered and its two chroma samples are replicated onto both pixels. Sustained throughput is 1 pixel/cycle.

## Interface
- `CW`, default 8: component width. Input beat is 2·CW, output beat is 3·CW.
- `CHROMA_FILL`, default 8'h80: chroma value used when a pixel has no partner chroma available.

- `aclk` input 1: single clock; all logic on the rising edge.
- `areset` input 1: synchronous, active-high reset.
- `s_axis_video_tdata` input 2·CW: {C, Y}. Even pixel carries chroma A; odd pixel carries chroma B.
- `s_axis_video_tvalid` input 1: input beat valid.
- `s_axis_video_tready` output 1: input beat accepted when valid & ready.
- `s_axis_video_tuser` input 1: start of frame, on the first pixel.
- `s_axis_video_tlast` input 1: end of line.
- `m_axis_video_tdata` output 3·CW: {B, A, Y}, bits [3CW-1:2CW]=B, [2CW-1:CW]=A, [CW-1:0]=Y.
- `m_axis_video_tvalid` output 1: output beat valid.
- `m_axis_video_tready` input 1: downstream ready.
- `m_axis_video_tuser` output 1: start of frame.
- `m_axis_video_tlast` output 1: end of line.

## Operation
- **Capture stage.** This is a pair register holding E (Y, A, user, last) and O (Y, B, last), plus a `par` bit, where 0 means the next beat is even.
- **Accepting a beat with par=0:**
  - Load E and set par=1.
  - If tlast=1 on this beat, the pair is an orphan. Mark it complete with B=`fill_b` and set par=0.
- **Accepting a beat with par=1:**
  - Load O and mark the pair complete.
  - Set par=0 and update `fill_b` with B.
- **`fill_b` register.**
  - Set to CHROMA_FILL at reset, after any accepted tlast, and on any accepted tuser.
  - Otherwise it holds the last B of the current line.
- **tuser while par=1.**
  - The held E is closed as an orphan first: it is emitted with B=`fill_b` and last=0.
  - The tuser beat is then treated as even (par forced to 0).
  - While this flush is pending, tready is 0.
- **Emit stage.** A complete pair moves to the emit registers when emit is empty, or when emit is draining its final beat this cycle.
  - Beat 1 (even): {B, A, E.Y}, tuser=E.user, tlast=E.last.
  - Beat 2 (odd): {B, A, O.Y}, tuser=0, tlast=O.last.
  - Orphan pairs emit beat 1 only.
- **Emit state machine:**
  - EMPTY → EMIT_E when a pair is loaded.
  - EMIT_E → EMIT_O on m_tready, for a full pair.
  - EMIT_E → EMPTY or EMIT_E (next pair loaded) on m_tready, for an orphan.
  - EMIT_O → EMPTY or EMIT_E (next pair loaded) on m_tready.
- **tready** = !areset & (capture not complete, or complete pair transferring this cycle) & no flush pending.
- **Output stability.** Output data and flags are held stable while tvalid=1 and tready=0.

## Timing
- **Reset values:** m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, s_tready=0 during reset; par=0, `fill_b`=CHROMA_FILL, emit=EMPTY.
- s_tready rises the first cycle after areset deasserts.
- **Latency:**
  - Even output valid 1 cycle after the odd beat is accepted, which is 2 cycles after the even beat.
  - Orphan output valid 1 cycle after acceptance.
- **Throughput:** back-to-back input at 1 beat/cycle with m_tready=1 never deasserts s_tready, except during a tuser flush.
- **Backpressure:** m_tready=0 stalls emit. The capture stage fills one pair, then s_tready drops. No beat is lost or duplicated.
- **Reset mid-frame:** all partial pairs are discarded. The next beat after reset is treated as even.
- **Simultaneous events:** a pair transfer and a new even capture in the same cycle are both legal and required.

## Structure
- Shared package `c_video_pkg` holds:
  - `CW`.
  - `CHROMA_FILL`.
  - Component slice constants (Y/A/B bit positions).
  - Emit state enum {EMPTY, EMIT_E, EMIT_O}.
- Natural sub-module: `c_usample_pair`, the capture stage (par, `fill_b`, orphan/flush logic). It presents a valid/ready pair interface to the emit FSM in the top level.

## Test plan
- **Basic pair.** Input {0x11,0x01},{0x22,0x02} (C,Y), m_tready=1 → outputs 0x221101 then 0x221102, first output 2 cycles after the first input.
- **Full-rate line.** Input a 1920-pixel line at 1 beat/cycle, tuser on the first beat, tlast on the last → 1920 outputs; tuser only on output 0, tlast only on output 1919; s_tready stays 1 throughout.
- **Odd-width line.** Input 3 pixels, chroma 0x10,0x20,0x30, tlast on the third → third output {0x20,0x30,Y2} (B=`fill_b`=0x20). A 1-pixel line → {0x80,A,Y}.
- **Random backpressure.** Drive m_tready randomly over 10k beats, comparing against a reference model → no loss, no duplication, and output stable whenever tvalid=1 and tready=0.
- **tuser mid-pair.** Send an even pixel, then a tuser beat → the orphan is emitted with B=0x80 and last=0; the tuser beat starts a new pair; exactly one cycle of tready=0.
- **Reset mid-pair.** Accept an even beat, assert areset for 1 cycle → m_tvalid=0; the next accepted beat is treated as even; the stale E is never emitted.

Source files
------------

// File: rtl/c_video_pkg.sv
// Shared video definitions for the chroma resampling blocks.
// Holds the default component width and fill chroma, the component slot
// positions inside input and output beats, and the emit state encoding.
package c_video_pkg;
  localparam int CW = 8;
  localparam logic [CW-1:0] CHROMA_FILL = 8'h80;

  // Component slots; a slot S of a beat occupies bits [S*CW +: CW].
  localparam int IN_Y_SLOT  = 0;  // 4:2:2 beat {C, Y}
  localparam int IN_C_SLOT  = 1;
  localparam int OUT_Y_SLOT = 0;  // 4:4:4 beat {B, A, Y}
  localparam int OUT_A_SLOT = 1;
  localparam int OUT_B_SLOT = 2;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    EMIT_E = 2'd1,
    EMIT_O = 2'd2
  } emit_state_e;
endpackage

// File: rtl/c_usample_pair.sv
// Capture stage of the 4:2:2 -> 4:4:4 upsampler.
// Collects an even/odd pixel pair (or a lone even "orphan" pixel) and offers
// it on a valid/ready pair interface.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   s_data_i/valid/ready   4:2:2 input beat {C, Y} with handshake
//   s_user_i, s_last_i     start of frame / end of line
//   pair_vld_o/rdy_i       completed-pair handshake toward the emit stage
//   pair_*_o               pair contents: Y of both pixels, chroma A and B,
//                          flags, and whether the pair is an orphan
module c_usample_pair
  import c_video_pkg::*;
#(
  parameter int              CW          = c_video_pkg::CW,
  parameter logic [CW-1:0]   CHROMA_FILL = c_video_pkg::CHROMA_FILL
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2*CW-1:0] s_data_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic            s_user_i,
  input  logic            s_last_i,
  output logic            pair_vld_o,
  input  logic            pair_rdy_i,
  output logic [CW-1:0]   pair_ey_o,
  output logic [CW-1:0]   pair_oy_o,
  output logic [CW-1:0]   pair_a_o,
  output logic [CW-1:0]   pair_b_o,
  output logic            pair_user_o,
  output logic            pair_elast_o,
  output logic            pair_olast_o,
  output logic            pair_orphan_o
);

  logic          par_q, par_d, cplt_q, cplt_d, orphan_q, orphan_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] ey_q, ey_d, oy_q, oy_d, a_q, a_d, b_q, b_d;
  logic          user_q, user_d, elast_q, elast_d, olast_q, olast_d;
  logic [CW-1:0] in_y, in_c, fill_eff;
  logic          xfer, flush, accept;

  assign in_y = s_data_i[IN_Y_SLOT*CW +: CW];
  assign in_c = s_data_i[IN_C_SLOT*CW +: CW];

  assign xfer      = cplt_q & pair_rdy_i;
  // A start-of-frame beat arriving while an even pixel is held must first
  // close that pixel as an orphan; the beat waits one cycle for it.
  assign flush     = s_valid_i & s_user_i & par_q;
  assign s_ready_o = ~rst_i & (~cplt_q | xfer) & ~flush;
  assign accept    = s_valid_i & s_ready_o;
  // A new frame restarts the fill chroma even for its own first pixel.
  assign fill_eff  = s_user_i ? CHROMA_FILL : fill_q;

  always_comb begin
    par_d    = par_q;
    cplt_d   = cplt_q;
    orphan_d = orphan_q;
    fill_d   = fill_q;
    ey_d     = ey_q;
    oy_d     = oy_q;
    a_d      = a_q;
    b_d      = b_q;
    user_d   = user_q;
    elast_d  = elast_q;
    olast_d  = olast_q;

    if (xfer) cplt_d = 1'b0;

    if (flush) begin
      cplt_d   = 1'b1;
      orphan_d = 1'b1;
      b_d      = fill_q;
      par_d    = 1'b0;
    end

    if (accept) begin
      if (!par_q) begin
        ey_d     = in_y;
        a_d      = in_c;
        user_d   = s_user_i;
        elast_d  = s_last_i;
        orphan_d = s_last_i;
        if (s_last_i) begin
          cplt_d = 1'b1;
          b_d    = fill_eff;
          par_d  = 1'b0;
        end else begin
          par_d  = 1'b1;
        end
      end else begin
        oy_d     = in_y;
        b_d      = in_c;
        olast_d  = s_last_i;
        orphan_d = 1'b0;
        cplt_d   = 1'b1;
        par_d    = 1'b0;
        fill_d   = in_c;
      end
      if (s_last_i || s_user_i) fill_d = CHROMA_FILL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q    <= 1'b0;
      cplt_q   <= 1'b0;
      orphan_q <= 1'b0;
      fill_q   <= CHROMA_FILL;
    end else begin
      par_q    <= par_d;
      cplt_q   <= cplt_d;
      orphan_q <= orphan_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ey_q    <= ey_d;
    oy_q    <= oy_d;
    a_q     <= a_d;
    b_q     <= b_d;
    user_q  <= user_d;
    elast_q <= elast_d;
    olast_q <= olast_d;
  end

  assign pair_vld_o    = cplt_q;
  assign pair_ey_o     = ey_q;
  assign pair_oy_o     = oy_q;
  assign pair_a_o      = a_q;
  assign pair_b_o      = b_q;
  assign pair_user_o   = user_q;
  assign pair_elast_o  = elast_q;
  assign pair_olast_o  = olast_q;
  assign pair_orphan_o = orphan_q;

endmodule

// File: rtl/c_usample.sv
// 4:2:2 -> 4:4:4 chroma upsampler (AXI4-Stream video, 1 pixel/cycle).
// Each captured pixel pair is replayed as two 4:4:4 beats sharing both
// chroma samples; orphan pixels replay as a single beat.
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   s_axis_video_*         4:2:2 input {C, Y}, tuser = SOF, tlast = EOL
//   m_axis_video_*         4:4:4 output {B, A, Y}, tuser = SOF, tlast = EOL
module c_usample
  import c_video_pkg::*;
#(
  parameter int            CW          = c_video_pkg::CW,
  parameter logic [CW-1:0] CHROMA_FILL = c_video_pkg::CHROMA_FILL
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [2*CW-1:0] s_axis_video_tdata,
  input  logic            s_axis_video_tvalid,
  output logic            s_axis_video_tready,
  input  logic            s_axis_video_tuser,
  input  logic            s_axis_video_tlast,
  output logic [3*CW-1:0] m_axis_video_tdata,
  output logic            m_axis_video_tvalid,
  input  logic            m_axis_video_tready,
  output logic            m_axis_video_tuser,
  output logic            m_axis_video_tlast
);

  logic          pair_vld, pair_rdy;
  logic [CW-1:0] pair_ey, pair_oy, pair_a, pair_b;
  logic          pair_user, pair_elast, pair_olast, pair_orphan;

  c_usample_pair #(
    .CW          (CW),
    .CHROMA_FILL (CHROMA_FILL)
  ) u_pair (
    .clk_i         (aclk),
    .rst_i         (areset),
    .s_data_i      (s_axis_video_tdata),
    .s_valid_i     (s_axis_video_tvalid),
    .s_ready_o     (s_axis_video_tready),
    .s_user_i      (s_axis_video_tuser),
    .s_last_i      (s_axis_video_tlast),
    .pair_vld_o    (pair_vld),
    .pair_rdy_i    (pair_rdy),
    .pair_ey_o     (pair_ey),
    .pair_oy_o     (pair_oy),
    .pair_a_o      (pair_a),
    .pair_b_o      (pair_b),
    .pair_user_o   (pair_user),
    .pair_elast_o  (pair_elast),
    .pair_olast_o  (pair_olast),
    .pair_orphan_o (pair_orphan)
  );

  emit_state_e   state_q, state_d;
  logic [CW-1:0] em_ey_q, em_oy_q, em_a_q, em_b_q;
  logic          em_user_q, em_elast_q, em_olast_q, em_orphan_q;
  logic          last_beat, load;

  // The final beat of the held pair leaves this cycle, so the next pair may
  // overwrite the emit registers without a bubble.
  assign last_beat = m_axis_video_tready &
                     ((state_q == EMIT_O) || (state_q == EMIT_E && em_orphan_q));
  assign pair_rdy  = (state_q == EMPTY) || last_beat;
  assign load      = pair_vld & pair_rdy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:  if (load) state_d = EMIT_E;
      EMIT_E: if (m_axis_video_tready) begin
                if (!em_orphan_q) state_d = EMIT_O;
                else              state_d = load ? EMIT_E : EMPTY;
              end
      EMIT_O: if (m_axis_video_tready) state_d = load ? EMIT_E : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (load) begin
      em_ey_q     <= pair_ey;
      em_oy_q     <= pair_oy;
      em_a_q      <= pair_a;
      em_b_q      <= pair_b;
      em_user_q   <= pair_user;
      em_elast_q  <= pair_elast;
      em_olast_q  <= pair_olast;
      em_orphan_q <= pair_orphan;
    end
  end

  // Outputs are zero whenever nothing is being presented.
  always_comb begin
    m_axis_video_tdata = '0;
    m_axis_video_tuser = 1'b0;
    m_axis_video_tlast = 1'b0;
    case (state_q)
      EMIT_E: begin
        m_axis_video_tdata[OUT_B_SLOT*CW +: CW] = em_b_q;
        m_axis_video_tdata[OUT_A_SLOT*CW +: CW] = em_a_q;
        m_axis_video_tdata[OUT_Y_SLOT*CW +: CW] = em_ey_q;
        m_axis_video_tuser = em_user_q;
        m_axis_video_tlast = em_elast_q;
      end
      EMIT_O: begin
        m_axis_video_tdata[OUT_B_SLOT*CW +: CW] = em_b_q;
        m_axis_video_tdata[OUT_A_SLOT*CW +: CW] = em_a_q;
        m_axis_video_tdata[OUT_Y_SLOT*CW +: CW] = em_oy_q;
        m_axis_video_tlast = em_olast_q;
      end
      default: ;
    endcase
  end

  assign m_axis_video_tvalid = (state_q != EMPTY);

endmodule

// File: tb/tb_c_usample.sv
module tb_c_usample;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic        s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast;
  logic        m_tready = 1'b1;

  c_usample dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tready (s_tready),
    .s_axis_video_tuser  (s_tuser),
    .s_axis_video_tlast  (s_tlast),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tready (m_tready),
    .m_axis_video_tuser  (m_tuser),
    .m_axis_video_tlast  (m_tlast)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct packed {logic [23:0] d; logic u; logic l;} beat_t;
  beat_t exp_q[$];
  beat_t log_q[$];
  int checks = 0, errors = 0;
  int rdy_low = 0;
  bit bp_en = 1'b0;

  // Reference model: a pending even pixel and the running fill chroma.
  bit         m_have;
  logic [7:0] m_ey, m_ea, m_fill;
  bit         m_eu;

  function automatic void model_reset();
    m_have = 1'b0;
    m_fill = 8'h80;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic [7:0] c, input logic [7:0] y,
                                       input bit u, input bit l);
    if (u) begin
      if (m_have) begin
        exp_q.push_back('{d: {m_fill, m_ea, m_ey}, u: m_eu, l: 1'b0});
        m_have = 1'b0;
      end
      m_fill = 8'h80;
    end
    if (!m_have) begin
      if (l) begin
        exp_q.push_back('{d: {m_fill, c, y}, u: u, l: 1'b1});
        m_fill = 8'h80;
      end else begin
        m_have = 1'b1; m_ey = y; m_ea = c; m_eu = u;
      end
    end else begin
      exp_q.push_back('{d: {c, m_ea, m_ey}, u: m_eu, l: 1'b0});
      exp_q.push_back('{d: {c, m_ea, y}, u: 1'b0, l: l});
      m_have = 1'b0;
      m_fill = l ? 8'h80 : c;
    end
  endfunction

  always @(posedge aclk) begin
    #1;
    m_tready = bp_en ? ($urandom_range(0, 9) < 6) : 1'b1;
  end

  bit    prev_stall = 1'b0;
  beat_t prev_b;
  always @(negedge aclk) begin
    if (areset) begin
      model_reset();
      prev_stall = 1'b0;
    end else begin
      beat_t a, e;
      a = '{d: m_tdata, u: m_tuser, l: m_tlast};
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || a != prev_b) begin
          errors++;
          $display("FAIL hold: got v=%0b %h/%0b/%0b need %h/%0b/%0b", m_tvalid,
                   a.d, a.u, a.l, prev_b.d, prev_b.u, prev_b.l);
        end
      end
      if (m_tvalid && m_tready) begin
        log_q.push_back(a);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h/%0b/%0b need none", a.d, a.u, a.l);
        end else begin
          e = exp_q.pop_front();
          if (a != e) begin
            errors++;
            $display("FAIL beat: got %h/%0b/%0b need %h/%0b/%0b", a.d, a.u, a.l, e.d, e.u, e.l);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_b = a;
      if (s_tvalid && !s_tready) rdy_low++;
      if (s_tvalid && s_tready) model_accept(s_tdata[15:8], s_tdata[7:0], s_tuser, s_tlast);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %h need %h", name, got, need);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] y, input bit u, input bit l,
                      output int acc_cyc);
    int n = 0;
    s_tdata = {c, y}; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      n++;
      if (n > 1000) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no tready need tready");
        break;
      end
    end
    acc_cyc = cyc + 1;
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin
      @(negedge aclk); n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_tvalid) begin
      errors++;
      $display("FAIL drain: got %0d pending need 0", exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    int t, base, rl, nu, nl, n;
    // Reset state, with input valid held high to show tready stays low.
    s_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata",  32'(m_tdata), 0);
    chk("rst_tuser",  32'(m_tuser), 0);
    chk("rst_tlast",  32'(m_tlast), 0);
    chk("rst_tready", 32'(s_tready), 0);
    s_tvalid = 1'b0;
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    chk("tready_after_rst", 32'(s_tready), 1);
    @(posedge aclk); #1;

    // Basic pair and first-output latency.
    base = log_q.size();
    send(8'h11, 8'h01, 1'b0, 1'b0, t);
    send(8'h22, 8'h02, 1'b0, 1'b1, n);
    n = 0;
    while (!m_tvalid && n < 20) begin @(negedge aclk); n++; end
    chk("latency", 32'(cyc - t), 2);
    drain();
    chk("basic_n", 32'(log_q.size() - base), 2);
    chk("basic_0", 32'(log_q[base].d), 32'h221101);
    chk("basic_1", 32'(log_q[base+1].d), 32'h221102);

    // Odd-width line, then a one-pixel line.
    base = log_q.size();
    send(8'h10, 8'hA0, 1'b0, 1'b0, t);
    send(8'h20, 8'hA1, 1'b0, 1'b0, t);
    send(8'h30, 8'hA2, 1'b0, 1'b1, t);
    send(8'h44, 8'hB0, 1'b0, 1'b1, t);
    drain();
    chk("odd_n", 32'(log_q.size() - base), 4);
    chk("odd_orphan", 32'(log_q[base+2].d), 32'h2030A2);
    chk("odd_orphan_last", 32'(log_q[base+2].l), 1);
    chk("one_px", 32'(log_q[base+3].d), 32'h8044B0);

    // Full-rate 1920-pixel line.
    base = log_q.size();
    rl = rdy_low;
    for (int i = 0; i < 1920; i++)
      send(8'(i * 3), 8'(i), i == 0, i == 1919, t);
    chk("line_tready_low", 32'(rdy_low - rl), 0);
    drain();
    chk("line_n", 32'(log_q.size() - base), 1920);
    nu = 0; nl = 0;
    for (int i = 0; i < 1920; i++) begin
      nu += int'(log_q[base+i].u);
      nl += int'(log_q[base+i].l);
    end
    chk("line_user0", 32'(log_q[base].u), 1);
    chk("line_last", 32'(log_q[base+1919].l), 1);
    chk("line_nuser", 32'(nu), 1);
    chk("line_nlast", 32'(nl), 1);

    // Start of frame arriving on what would be the odd pixel.
    base = log_q.size();
    rl = rdy_low;
    send(8'h55, 8'h05, 1'b0, 1'b0, t);
    send(8'h66, 8'h06, 1'b1, 1'b0, t);
    send(8'h77, 8'h07, 1'b0, 1'b1, t);
    drain();
    chk("flush_tready_low", 32'(rdy_low - rl), 1);
    chk("flush_n", 32'(log_q.size() - base), 3);
    chk("flush_orphan", {6'd0, log_q[base]}, {6'd0, 24'h805505, 1'b0, 1'b0});
    chk("flush_new_e", {6'd0, log_q[base+1]}, {6'd0, 24'h776606, 1'b1, 1'b0});
    chk("flush_new_o", {6'd0, log_q[base+2]}, {6'd0, 24'h776607, 1'b0, 1'b1});

    // Reset with an even pixel held.
    base = log_q.size();
    send(8'h99, 8'h09, 1'b0, 1'b0, t);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst_tvalid", 32'(m_tvalid), 0);
    @(posedge aclk); #1 areset = 1'b0;
    send(8'h12, 8'h0A, 1'b0, 1'b0, t);
    send(8'h34, 8'h0B, 1'b0, 1'b1, t);
    drain();
    chk("midrst_n", 32'(log_q.size() - base), 2);
    chk("midrst_0", 32'(log_q[base].d), 32'h34120A);
    chk("midrst_1", 32'(log_q[base+1].d), 32'h34120B);

    // Random traffic with random downstream backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 63) == 0),
           (i == 9999) || ($urandom_range(0, 15) == 0), t);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge aclk); #1;
      end
    end
    bp_en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
